apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_master.sv | 166 ++++++++++++++++
 tb/tb_apb_master.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//
// Purpose:
//   Shared definitions for the APB master: the transfer state encoding and
//   the default bus widths used when a block is not parameterised explicitly.
//
// Contents:
//   APB_ADDR_W   default APB address width (8)
//   APB_DATA_W   default APB data width (32)
//   apb_state_e  transfer phase: IDLE, SETUP, ACCESS
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    // IDLE   : no transfer, command port open
    // SETUP  : first bus cycle, psel=1 penable=0
    // ACCESS : second and later bus cycles, psel=1 penable=1
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Purpose:
//   Single-outstanding APB master. A command accepted on the command port is
//   turned into one APB transfer (SETUP then ACCESS), and its completion is
//   reported as a one-cycle pulse on the response port.
//
// Configuration:
//   APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees pready low
//                          for TIMEOUT consecutive cycles is aborted and
//                          reported with rsp_err=1. When undefined the block
//                          waits in ACCESS for as long as the slave stalls and
//                          has no counter at all.
//
// Parameters:
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  stalled ACCESS cycles before abort (1..255, timeout build only)
//
// Ports:
//   pclk, preset          clock and synchronous active-high reset
//   cmd_valid, cmd_ready  command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata             command payload
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    completion payload, held until the next pulse
//   paddr, psel, penable,
//   pwrite, pwdata        APB request signals (all registered)
//   prdata, pready,
//   pslverr               APB response signals
//
// Handshake:
//   A command transfers on a cycle where cmd_valid && cmd_ready are both high
//   at the rising edge. cmd_ready is high exactly while the state is IDLE and
//   does not depend on cmd_valid; cmd_valid is ignored in any other state, so
//   the requester must hold the command until it sees the handshake. The
//   response side has no back-pressure: rsp_valid is high for exactly one
//   cycle per completed or aborted transfer and is never stretched.
//
// Debug:
//   The transfer phase lives in the register `state` (apb_state_e), readable
//   hierarchically by checkers.
// -----------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e state;

`ifdef APB_MASTER_TIMEOUT_EN
    // Counts ACCESS cycles that have already seen pready low. The abort fires
    // on the edge that ends the TIMEOUT-th such cycle, so a pready arriving in
    // that last cycle still wins and completes the transfer normally.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
`endif

    // Purely a decode of the state register, so it is glitch-free and never
    // depends on cmd_valid.
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge pclk) begin
        if (preset) begin
            // Reset also abandons any transfer in flight without a response.
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            // rsp_valid is a single-cycle pulse; only the completing branch
            // raises it again.
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        // Request fields are captured once here and stay
                        // untouched until the next accept.
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                SETUP: begin
                    // pready/pslverr are not looked at here.
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        // Read data is only meaningful for an error-free read.
                        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule : apb_master

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// Directed bench for apb_master. Inputs are driven 1 time unit after each
// rising edge and outputs are sampled at that same point, so every check in a
// "cycle" sees the registered state produced by the preceding edge.
// Cycle T is the cycle in which cmd_valid is presented with cmd_ready high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_master;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              pclk;
    logic              preset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int checks   = 0;
    int failures = 0;

    apb_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apply_reset();
        preset = 1'b1;
        tick();
        tick();
        preset = 1'b0;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        // {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err}
        if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err} !== 6'b000100) begin
            $display("FAIL reset_ctrl got=%b exp=000100",
                     {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err});
            failures++;
        end
        checks++;
        if ({paddr, pwdata, rsp_rdata} !== '0) begin
            $display("FAIL reset_data paddr=%h pwdata=%h rsp_rdata=%h exp=0", paddr, pwdata, rsp_rdata);
            failures++;
        end
        checks++;
    endtask

    task automatic test_write();
        // cycle T: present command, slave always ready, prdata non-zero
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEADBEEF;
        pready = 1'b1; prdata = 32'hAAAA5555;
        if ({cmd_ready, psel} !== 2'b10) begin
            $display("FAIL wr_T got=%b exp=10", {cmd_ready, psel}); failures++;
        end
        checks++;
        tick(); // T+1 SETUP
        cmd_valid = 1'b0;
        if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1000) begin
            $display("FAIL wr_T1_ctrl got=%b exp=1000", {psel, penable, cmd_ready, rsp_valid}); failures++;
        end
        checks++;
        if ({paddr, pwrite, pwdata} !== {8'h10, 1'b1, 32'hDEADBEEF}) begin
            $display("FAIL wr_T1_req paddr=%h pwrite=%b pwdata=%h exp=10/1/deadbeef", paddr, pwrite, pwdata);
            failures++;
        end
        checks++;
        tick(); // T+2 ACCESS
        if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1100) begin
            $display("FAIL wr_T2_ctrl got=%b exp=1100", {psel, penable, cmd_ready, rsp_valid}); failures++;
        end
        checks++;
        tick(); // T+3 response
        pready = 1'b0;
        if ({rsp_valid, rsp_err, cmd_ready, psel, penable} !== 5'b10100) begin
            $display("FAIL wr_T3_rsp got=%b exp=10100", {rsp_valid, rsp_err, cmd_ready, psel, penable}); failures++;
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            $display("FAIL wr_T3_rdata got=%h exp=00000000", rsp_rdata); failures++;
        end
        checks++;
        tick(); // T+4 pulse gone
        if (rsp_valid !== 1'b0) begin
            $display("FAIL wr_T4_pulse got=%b exp=0", rsp_valid); failures++;
        end
        checks++;
    endtask

    task automatic test_read_wait();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_wdata = 32'h0;
        pready = 1'b0; prdata = 32'h0;
        tick(); // T+1 SETUP; pready/pslverr here must be ignored, new cmd ignored
        cmd_addr = 8'h77; cmd_write = 1'b1;
        pready = 1'b1; pslverr = 1'b1;
        if ({psel, penable, cmd_ready} !== 3'b100) begin
            $display("FAIL rd_T1_ctrl got=%b exp=100", {psel, penable, cmd_ready}); failures++;
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            tick(); // T+2..T+4 ACCESS with pready low
            pready = 1'b0; pslverr = 1'b0;
            if ({psel, penable, rsp_valid, cmd_ready, pwrite, paddr} !== {4'b1100, 1'b0, 8'h20}) begin
                $display("FAIL rd_wait%0d psel=%b pen=%b rv=%b rdy=%b pwrite=%b paddr=%h exp=1/1/0/0/0/20",
                         i, psel, penable, rsp_valid, cmd_ready, pwrite, paddr);
                failures++;
            end
            checks++;
        end
        tick(); // T+5 ACCESS, slave completes
        cmd_valid = 1'b0;
        pready = 1'b1; prdata = 32'h12345678;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            $display("FAIL rd_T5_ctrl got=%b exp=110", {psel, penable, rsp_valid}); failures++;
        end
        checks++;
        tick(); // T+6 response
        pready = 1'b0; prdata = 32'h0;
        if ({rsp_valid, rsp_err, psel} !== 3'b100 || rsp_rdata !== 32'h12345678) begin
            $display("FAIL rd_T6_rsp rv=%b err=%b psel=%b rdata=%h exp=1/0/0/12345678",
                     rsp_valid, rsp_err, psel, rsp_rdata);
            failures++;
        end
        checks++;
        tick(); // T+7 rdata held after the pulse
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h12345678) begin
            $display("FAIL rd_hold rv=%b rdata=%h exp=0/12345678", rsp_valid, rsp_rdata); failures++;
        end
        checks++;
    endtask

    task automatic test_slverr();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h24;
        tick(); // SETUP
        cmd_valid = 1'b0;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
        tick(); // ACCESS
        tick(); // response
        pready = 1'b0; pslverr = 1'b0;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
            $display("FAIL err_rsp rv=%b err=%b rdata=%h exp=1/1/00000000", rsp_valid, rsp_err, rsp_rdata);
            failures++;
        end
        checks++;
        tick();
        tick();
        if ({rsp_valid, rsp_err} !== 2'b01) begin
            $display("FAIL err_hold got=%b exp=01", {rsp_valid, rsp_err}); failures++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'h00000001;
        pready = 1'b1; prdata = 32'h0BADBEEF;
        tick(); // T+1 SETUP of A, switch the held command to B
        cmd_write = 1'b0; cmd_addr = 8'h40; cmd_wdata = 32'h0;
        if (paddr !== 8'h30) begin
            $display("FAIL b2b_A_addr got=%h exp=30", paddr); failures++;
        end
        checks++;
        tick(); // T+2 ACCESS of A
        tick(); // T+3 response A, B accepted here
        if ({rsp_valid, rsp_err, cmd_ready, psel} !== 4'b1010) begin
            $display("FAIL b2b_gap got=%b exp=1010", {rsp_valid, rsp_err, cmd_ready, psel}); failures++;
        end
        checks++;
        tick(); // T+4 SETUP of B
        cmd_valid = 1'b0;
        if ({psel, penable, pwrite, paddr} !== {3'b100, 8'h40}) begin
            $display("FAIL b2b_B_setup psel=%b pen=%b pwrite=%b paddr=%h exp=1/0/0/40",
                     psel, penable, pwrite, paddr);
            failures++;
        end
        checks++;
        tick(); // T+5 ACCESS of B
        tick(); // T+6 response B
        pready = 1'b0;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADBEEF) begin
            $display("FAIL b2b_B_rsp rv=%b rdata=%h exp=1/0badbeef", rsp_valid, rsp_rdata); failures++;
        end
        checks++;
        tick();
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50;
        pready = 1'b0; prdata = 32'hFFFFFFFF;
        tick(); // T+1 SETUP
        cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        // ACCESS cycles T+2..T+5 stall, abort response expected at T+6.
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                $display("FAIL to_stall%0d got=%b exp=110", i, {psel, penable, rsp_valid}); failures++;
            end
            checks++;
        end
        tick(); // T+6
        if ({rsp_valid, rsp_err, psel, penable, cmd_ready} !== 5'b11001 || rsp_rdata !== 32'h0) begin
            $display("FAIL to_abort got=%b rdata=%h exp=11001/00000000",
                     {rsp_valid, rsp_err, psel, penable, cmd_ready}, rsp_rdata);
            failures++;
        end
        checks++;
        // pready in the last allowed ACCESS cycle completes normally.
        tick();
        cmd_valid = 1'b1; cmd_addr = 8'h54;
        tick(); // SETUP
        cmd_valid = 1'b0;
        tick(); tick(); tick(); // ACCESS cycles 1..3 stalled
        tick(); // ACCESS cycle 4
        pready = 1'b1; prdata = 32'h5A5A0001;
        tick();
        pready = 1'b0;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h5A5A0001) begin
            $display("FAIL to_precedence rv=%b err=%b rdata=%h exp=1/0/5a5a0001",
                     rsp_valid, rsp_err, rsp_rdata);
            failures++;
        end
        checks++;
        tick();
`else
        // No timeout: the stalled transfer must stay in ACCESS indefinitely.
        for (int i = 0; i < 110; i++) begin
            tick();
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                $display("FAIL nto_stall%0d got=%b exp=110", i, {psel, penable, rsp_valid}); failures++;
            end
            checks++;
        end
        apply_reset();
        if ({psel, cmd_ready} !== 2'b01) begin
            $display("FAIL nto_recover got=%b exp=01", {psel, cmd_ready}); failures++;
        end
        checks++;
`endif
    endtask

    task automatic test_reset_mid();
        int seen_rsp;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h60; cmd_wdata = 32'h13572468;
        pready = 1'b0;
        tick(); // T+1 SETUP
        cmd_valid = 1'b0;
        tick(); // T+2 ACCESS: reset with a ready slave at the same time
        preset = 1'b1; pready = 1'b1;
        if ({psel, penable} !== 2'b11) begin
            $display("FAIL rst_mid_pre got=%b exp=11", {psel, penable}); failures++;
        end
        checks++;
        tick(); // T+3
        preset = 1'b0; pready = 1'b0;
        if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0010) begin
            $display("FAIL rst_mid_post got=%b exp=0010", {psel, penable, cmd_ready, rsp_valid}); failures++;
        end
        checks++;
        if ({pwrite, paddr, pwdata} !== '0) begin
            $display("FAIL rst_mid_clear pwrite=%b paddr=%h pwdata=%h exp=0", pwrite, paddr, pwdata);
            failures++;
        end
        checks++;
        seen_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid) seen_rsp++;
        end
        if (seen_rsp !== 0) begin
            $display("FAIL rst_mid_norsp got=%0d exp=0", seen_rsp); failures++;
        end
        checks++;
    endtask

    // ---------------- sequence ----------------
    initial begin
        preset = 1'b1;
        idle_inputs();
        test_reset();
        tick();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so a stuck test can never hang the run.
    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule : tb_apb_master
